// File: rtl/io_unit_pkg.sv
// Shared CPU constants: controller opcodes and states, syscall codes and
// the IO unit state encoding.
package io_unit_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned SYS_CODE_W = 2;

   // Controller instruction set
   typedef enum logic [OPCODE_W-1:0] {
      OP_HALT    = 4'd0,
      OP_LOAD    = 4'd1,
      OP_STORE   = 4'd2,
      OP_ADD     = 4'd3,
      OP_SUB     = 4'd4,
      OP_JUMP    = 4'd5,
      OP_JUMPZ   = 4'd6,
      OP_SYSCALL = 4'd7
   } opcode_t;

   typedef enum logic [2:0] {
      CTL_FETCH  = 3'd0,
      CTL_DECODE = 3'd1,
      CTL_EXEC   = 3'd2,
      CTL_MEM    = 3'd3,
      CTL_IO     = 3'd4
   } ctl_state_t;

   // Syscall codes carried in the low bits of ACC
   typedef enum logic [SYS_CODE_W-1:0] {
      SYS_HALT  = 2'd0,
      SYS_READ  = 2'd1,
      SYS_WRITE = 2'd2,
      SYS_BAD   = 2'd3
   } sys_code_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      HALT  = 3'd4
   } io_state_t;

endpackage

// File: rtl/io_unit.sv
// Syscall unit: services READ/WRITE/HALT requests from the CPU controller
// over two valid/ready word channels.
module io_unit
   import io_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             runio,
   output logic             iobusy,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] dr_in,
   output logic [WIDTH-1:0] io_data,
   output logic             halted,
   output logic             bad_call,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   io_state_t        state, state_nxt;
   sys_code_t        code_q, code_nxt;
   sys_code_t        code_in;
   logic [WIDTH-1:0] dr_q, dr_nxt;
   logic [WIDTH-1:0] io_data_q, io_data_nxt;
   logic             halted_q, halted_nxt;
   logic             bad_q, bad_nxt;
   logic             unused_acc_hi;

   // Only the low bits of ACC select the call
   assign code_in       = sys_code_t'(acc_in[SYS_CODE_W-1:0]);
   assign unused_acc_hi = ^acc_in[WIDTH-1:SYS_CODE_W];

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         code_q    <= SYS_HALT;
         dr_q      <= '0;
         io_data_q <= '0;
         halted_q  <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         code_q    <= code_nxt;
         dr_q      <= dr_nxt;
         io_data_q <= io_data_nxt;
         halted_q  <= halted_nxt;
         bad_q     <= bad_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      code_nxt    = code_q;
      dr_nxt      = dr_q;
      io_data_nxt = io_data_q;
      halted_nxt  = halted_q;
      bad_nxt     = bad_q;

      unique case (state)
         IDLE: begin
            if (runio) begin
               code_nxt = code_in;
               dr_nxt   = dr_in;
               case (code_in)
                  SYS_HALT: begin
                     state_nxt  = HALT;
                     halted_nxt = 1'b1;
                  end
                  SYS_READ:  state_nxt = READ;
                  SYS_WRITE: state_nxt = WRITE;
                  SYS_BAD: begin
                     state_nxt = DONE;
                     bad_nxt   = 1'b1;
                  end
               endcase
            end
         end
         READ: begin
            if (in_valid && in_ready) begin
               io_data_nxt = in_data;
               state_nxt   = DONE;
            end
         end
         WRITE: begin
            if (out_valid && out_ready) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake strobes decode from registered state and latched code only
   assign in_ready  = (state == READ)  && (code_q == SYS_READ);
   assign out_valid = (state == WRITE) && (code_q == SYS_WRITE);
   assign out_data  = dr_q;

   // Busy follows runio so the controller stalls in the request cycle itself
   assign iobusy   = (state == HALT) || (runio && (state != DONE));
   assign io_data  = io_data_q;
   assign halted   = halted_q;
   assign bad_call = bad_q;

endmodule

// File: tb/tb_io_unit.sv
// Scoreboard bench for io_unit: directed syscalls with a controller model,
// expected completions and write words checked by an independent monitor.
module tb_io_unit;

   localparam int unsigned WIDTH = 16;

   typedef struct packed {
      logic [WIDTH-1:0] io;
      logic             bad;
   } done_t;

   logic             clock = 1'b0;
   logic             reset;
   logic             runio;
   logic             iobusy;
   logic [WIDTH-1:0] acc_in;
   logic [WIDTH-1:0] dr_in;
   logic [WIDTH-1:0] io_data;
   logic             halted;
   logic             bad_call;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   done_t            done_q[$];
   logic [WIDTH-1:0] wr_q[$];
   int               checks    = 0;
   int               errors    = 0;
   int               in_xfers  = 0;
   int               out_xfers = 0;

   io_unit #(.WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .runio     (runio),
      .iobusy    (iobusy),
      .acc_in    (acc_in),
      .dr_in     (dr_in),
      .io_data   (io_data),
      .halted    (halted),
      .bad_call  (bad_call),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic done_t mk_done(input logic [WIDTH-1:0] io, input logic bad);
      done_t d;
      d.io  = io;
      d.bad = bad;
      return d;
   endfunction

   // Monitor: pops expectations whenever the DUT completes a call or emits a word
   initial begin
      done_t e;
      forever begin
         @(negedge clock);
         if (reset === 1'b1) begin
            if (out_valid && out_ready) begin
               out_xfers++;
               if (wr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: out_data %0h with nothing queued", out_data);
               end else begin
                  check("write_word", 32'(out_data), 32'(wr_q.pop_front()));
               end
            end
            if (in_valid && in_ready) in_xfers++;
            if (runio && !iobusy) begin
               if (done_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: io_data %0h bad_call %0b", io_data, bad_call);
               end else begin
                  e = done_q.pop_front();
                  check("done_io_data", 32'(io_data), 32'(e.io));
                  check("done_bad_call", 32'(bad_call), 32'(e.bad));
               end
            end
         end
      end
   end

   // Controller model: raise runio, hold it through the first iobusy-low cycle
   task automatic syscall(input logic [WIDTH-1:0] code, input logic [WIDTH-1:0] dr,
                          input bit scramble, output int busy);
      bit seen_low = 1'b0;
      busy   = 0;
      runio  = 1'b1;
      acc_in = code;
      dr_in  = dr;
      for (int i = 0; i < 40 && !seen_low; i++) begin
         @(negedge clock);
         if (!iobusy) begin
            seen_low = 1'b1;
         end else begin
            busy++;
            if (scramble && busy == 1) begin
               @(posedge clock);
               #1;
               acc_in = '0;
               dr_in  = 16'hDEAD;
            end
         end
      end
      if (!seen_low) begin
         checks++;
         errors++;
         $display("FAIL syscall_timeout: code %0h still busy after 40 cycles", code);
      end
      @(posedge clock);
      #1;
      runio = 1'b0;
   endtask

   task automatic offer_in(input int delay, input logic [WIDTH-1:0] data);
      bit taken = 1'b0;
      repeat (delay) begin
         @(posedge clock);
         #1;
      end
      in_valid = 1'b1;
      in_data  = data;
      for (int i = 0; i < 40 && !taken; i++) begin
         @(negedge clock);
         if (in_ready) taken = 1'b1;
      end
      if (!taken) begin
         checks++;
         errors++;
         $display("FAIL in_timeout: word %0h never accepted", data);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic sink_out(input int stall, input logic [WIDTH-1:0] exp,
                           output int held, output bit stable);
      bit got = 1'b0;
      held      = 0;
      stable    = 1'b1;
      out_ready = (stall == 0);
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (out_valid) begin
            held++;
            if (out_data !== exp) stable = 1'b0;
            if (out_ready) begin
               got = 1'b1;
            end else if (held == stall) begin
               @(posedge clock);
               #1;
               out_ready = 1'b1;
            end
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL out_timeout: word %0h never transferred", exp);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, b2, held, in0, out0, good;
      bit stable;

      reset     = 1'b0;
      runio     = 1'b0;
      acc_in    = '0;
      dr_in     = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_iobusy",    32'(iobusy),    32'd0);
      check("reset_io_data",   32'(io_data),   32'd0);
      check("reset_halted",    32'(halted),    32'd0);
      check("reset_bad_call",  32'(bad_call),  32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data",  32'(out_data),  32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // READ with the input word arriving three cycles after the request
      @(posedge clock);
      #1;
      done_q.push_back(mk_done(16'h1234, 1'b0));
      in0 = in_xfers;
      fork
         syscall(16'h0001, 16'h0000, 1'b0, b);
         offer_in(3, 16'h1234);
      join
      check("read_busy_cycles", 32'(b), 32'd4);
      check("read_in_xfers",    32'(in_xfers - in0), 32'd1);
      check("read_io_data",     32'(io_data), 32'h1234);

      // WRITE with four cycles of backpressure
      @(posedge clock);
      #1;
      wr_q.push_back(16'hBEEF);
      done_q.push_back(mk_done(16'h1234, 1'b0));
      out0 = out_xfers;
      fork
         syscall(16'h0002, 16'hBEEF, 1'b0, b);
         sink_out(4, 16'hBEEF, held, stable);
      join
      check("write_valid_cycles", 32'(held), 32'd5);
      check("write_data_stable",  32'(stable), 32'd1);
      check("write_busy_cycles",  32'(b), 32'd6);
      check("write_out_xfers",    32'(out_xfers - out0), 32'd1);
      check("write_io_kept",      32'(io_data), 32'h1234);

      // Unknown code with both channels offering
      @(posedge clock);
      #1;
      done_q.push_back(mk_done(16'h1234, 1'b1));
      in0       = in_xfers;
      out0      = out_xfers;
      in_valid  = 1'b1;
      in_data   = 16'h7777;
      out_ready = 1'b1;
      syscall(16'h0003, 16'h0000, 1'b0, b);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bad_busy_cycles", 32'(b), 32'd1);
      check("bad_flag",        32'(bad_call), 32'd1);
      check("bad_in_xfers",    32'(in_xfers - in0), 32'd0);
      check("bad_out_xfers",   32'(out_xfers - out0), 32'd0);
      check("bad_io_kept",     32'(io_data), 32'h1234);

      // Back-to-back WRITE then READ, ACC/DR disturbed mid-call
      @(posedge clock);
      #1;
      wr_q.push_back(16'h0005);
      done_q.push_back(mk_done(16'h1234, 1'b1));
      done_q.push_back(mk_done(16'hFFFF, 1'b1));
      in0  = in_xfers;
      out0 = out_xfers;
      fork
         begin
            syscall(16'hF002, 16'h0005, 1'b1, b);
            syscall(16'h0001, 16'h0000, 1'b1, b2);
         end
         begin
            sink_out(0, 16'h0005, held, stable);
            offer_in(0, 16'hFFFF);
         end
      join
      check("b2b_write_busy",   32'(b), 32'd2);
      check("b2b_read_busy",    32'(b2), 32'd2);
      check("b2b_write_stable", 32'(stable), 32'd1);
      check("b2b_write_held",   32'(held), 32'd1);
      check("b2b_in_xfers",     32'(in_xfers - in0), 32'd1);
      check("b2b_out_xfers",    32'(out_xfers - out0), 32'd1);
      check("b2b_io_data",      32'(io_data), 32'hFFFF);
      check("b2b_not_halted",   32'(halted), 32'd0);

      // Reset while READ is waiting and a word is offered on the same edge
      @(posedge clock);
      #1;
      in0    = in_xfers;
      runio  = 1'b1;
      acc_in = 16'h0001;
      @(posedge clock);
      #1;
      @(negedge clock);
      check("midread_in_ready", 32'(in_ready), 32'd1);
      #1;
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'hAAAA;
      @(posedge clock);
      #1;
      reset    = 1'b1;
      runio    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check("midread_io_data",  32'(io_data), 32'd0);
      check("midread_in_ready_after", 32'(in_ready), 32'd0);
      check("midread_iobusy",   32'(iobusy), 32'd0);
      check("midread_bad_call", 32'(bad_call), 32'd0);
      check("midread_in_xfers", 32'(in_xfers - in0), 32'd0);

      // HALT: one-cycle runio pulse, then everything is ignored until reset
      @(posedge clock);
      #1;
      in0    = in_xfers;
      runio  = 1'b1;
      acc_in = 16'h0000;
      @(posedge clock);
      #1;
      runio = 1'b0;
      @(negedge clock);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_iobusy", 32'(iobusy), 32'd1);
      #1;
      runio     = 1'b1;
      acc_in    = 16'h0001;
      in_valid  = 1'b1;
      in_data   = 16'h5555;
      out_ready = 1'b1;
      good      = 0;
      repeat (5) begin
         @(negedge clock);
         if (iobusy && halted && !in_ready && !out_valid && io_data == 16'h0000) good++;
      end
      check("halt_stuck_cycles", 32'(good), 32'd5);
      check("halt_in_xfers",     32'(in_xfers - in0), 32'd0);
      #1;
      reset     = 1'b0;
      runio     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("halt_cleared", 32'(halted), 32'd0);
      check("halt_iobusy_cleared", 32'(iobusy), 32'd0);

      repeat (2) @(posedge clock);
      check("done_queue_drained",  32'(done_q.size()), 32'd0);
      check("write_queue_drained", 32'(wr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 16, machine word width (ACC, DR, data ports).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- runio  in  1  syscall request from CPU controller; held high until the cycle after iobusy is seen low
- iobusy  out  1  high while syscall is in progress
- acc_in  in  WIDTH  syscall code (low 2 bits used, rest ignored)
- dr_in  in  WIDTH  operand for WRITE
- io_data  out  WIDTH  READ result, selected into ACC by the controller
- halted  out  1  sticky halt indicator
- bad_call  out  1  sticky unknown-code flag
- in_valid / in_ready  in / out  1 each  external input word handshake
- in_data  in  WIDTH  external input word
- out_valid / out_ready  out / in  1 each  external output word handshake
- out_data  out  WIDTH  external output word

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, DONE, HALT.
REQ-004 SHALL, in IDLE with runio=1, latch the code and dr_in, then go to HALT (code 0), READ (code 1), WRITE (code 2) or DONE with bad_call<=1 (code 3).
REQ-005 SHALL drive iobusy combinationally = runio & (state != DONE), so iobusy is already 1 in the first cycle runio is high.
REQ-006 SHALL drive iobusy=1 in HALT regardless of runio; the CPU stays stalled until reset.
REQ-007 SHALL assert in_ready only in READ; on in_valid&in_ready, io_data<=in_data and go to DONE.
REQ-008 SHALL assert out_valid only in WRITE with out_data = latched DR; on out_valid&out_ready go to DONE.
REQ-009 SHALL keep out_data stable and out_valid high in WRITE until accepted (no withdrawal).
REQ-010 SHALL spend exactly one cycle in DONE (iobusy=0), then go to IDLE unconditionally.
REQ-011 SHALL hold io_data unchanged except on a READ transfer; value persists across later syscalls.
REQ-012 SHALL ignore runio while not in IDLE; a runio still high in IDLE after DONE SHALL start a new call (controller guarantees it drops).
REQ-013 SHALL give latency: handshake-ready external side -> DONE one cycle after entering READ/WRITE; total runio rise to iobusy fall = 2 cycles.
REQ-014 SHALL sample acc_in/dr_in only at the IDLE->busy transition; later changes have no effect.
REQ-015 SHALL set halted=1 on entering HALT; HALT has no exit except reset.

Reset
REQ-016 SHALL on reset=0 at a clock edge: state=IDLE, io_data=0, halted=0, bad_call=0, latched code/DR=0; in_ready=0, out_valid=0.
REQ-017 SHALL abort an in-progress READ/WRITE on reset with no transfer completed; a word offered on the same edge is dropped.
REQ-018 SHALL give reset priority over all other inputs.

Structure
REQ-019 SHALL take syscall codes (HALT=0, READ=1, WRITE=2) and state encodings from the shared CPU constants package alongside the controller's instruction and state constants.
REQ-020 SHALL be one flat module; no sub-module.

Verification
REQ-021 READ: acc_in=1, runio=1, in_data=16'h1234 valid 3 cycles later -> iobusy high until DONE, io_data=16'h1234, in_ready one cycle.
REQ-022 WRITE with backpressure: acc_in=2, dr_in=16'hBEEF, out_ready low 4 cycles -> out_valid held 5 cycles, out_data=16'hBEEF stable, single transfer, iobusy falls the cycle after.
REQ-023 HALT: acc_in=0, runio pulse -> halted=1, iobusy=1 permanently, later runio/in_valid ignored until reset.
REQ-024 Unknown code: acc_in=16'h0003 -> bad_call=1, DONE next cycle, io_data unchanged, no handshakes.
REQ-025 Reset mid-READ: reset low while in READ with in_valid=1 -> state IDLE, io_data=0, no transfer.
REQ-026 Back-to-back: WRITE 16'h0005 then READ 16'hFFFF driven by the controller model -> each call completes once, acc_in changes mid-call ignored.
